// File: rtl/instr_fe_pkg.sv
// Shared fetch-stage definitions: reset PC, NOP encoding, PC step and FSM state encoding.
package instr_fe_pkg;

    localparam int unsigned PcWidth = 32;
    localparam logic [PcWidth-1:0] PcResetDefault = 32'h0000_0000;
    localparam logic [31:0] NopInstr = 32'h0000_0013;
    localparam logic [PcWidth-1:0] PcIncr = 32'd4;

    typedef enum logic [1:0] {
        StFetch    = 2'd0,
        StDiscard  = 2'd1,
        StBuffered = 2'd2
    } fe_state_e;

    // Redirect targets are word aligned; bits [1:0] are dropped.
    function automatic logic [PcWidth-1:0] align_pc(input logic [PcWidth-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/instr_fe_skid.sv
// One-entry {instr, pc} skid buffer; holds a response that arrived while decode stalled.
module instr_fe_skid
    import instr_fe_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [31:0]        in_instr,
    input  logic [PcWidth-1:0] in_pc,
    output logic               valid,
    output logic [31:0]        out_instr,
    output logic [PcWidth-1:0] out_pc
);

    logic               valid_q;
    logic [31:0]        instr_q;
    logic [PcWidth-1:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NopInstr;
            pc_q    <= '0;
        end else begin
            if (clear || drain) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q <= 1'b1;
            end
            if (load && !clear) begin
                instr_q <= in_instr;
                pc_q    <= in_pc;
            end
        end
    end

    assign valid     = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/instr_fe.sv
// RV32I fetch stage: PC register, single-outstanding imem handshake, redirect/flush/stall handling.
module instr_fe
    import instr_fe_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PcResetDefault,
    parameter logic [31:0] NOP_INSTR = NopInstr
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        clk_en,
    input  logic        prev_stall,
    input  logic        prev_flush,
    input  logic        change_pc,
    input  logic [31:0] new_pc
);

    fe_state_e   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] redirect_q, redirect_d;
    logic        req_q, req_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        clk_en_q, clk_en_d;

    logic        ack_v;
    logic        skid_load, skid_drain, skid_clear;
    logic        skid_valid;
    logic [31:0] skid_instr, skid_pc;

    // Acks only count against a live request; stale acks after reset are ignored.
    assign ack_v = imem_ack & req_q;

    instr_fe_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .drain     (skid_drain),
        .clear     (skid_clear),
        .in_instr  (imem_data),
        .in_pc     (fetch_pc_q),
        .valid     (skid_valid),
        .out_instr (skid_instr),
        .out_pc    (skid_pc)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        redirect_d = redirect_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        clk_en_d   = clk_en_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        if (change_pc) begin
            clk_en_d   = 1'b0;
            instr_d    = NOP_INSTR;
            skid_clear = 1'b1;
            if (!req_q || ack_v) begin
                fetch_pc_d = align_pc(new_pc);
                state_d    = StFetch;
            end else begin
                // Request still in flight: its response must be dropped first.
                redirect_d = align_pc(new_pc);
                state_d    = StDiscard;
            end
        end else begin
            case (state_q)
                StFetch: begin
                    if (prev_stall) begin
                        if (ack_v) begin
                            skid_load  = 1'b1;
                            fetch_pc_d = fetch_pc_q + PcIncr;
                            state_d    = StBuffered;
                        end
                    end else if (prev_flush) begin
                        clk_en_d   = 1'b0;
                        instr_d    = NOP_INSTR;
                        skid_clear = 1'b1;
                        if (ack_v) begin
                            fetch_pc_d = fetch_pc_q + PcIncr;
                        end
                    end else if (ack_v) begin
                        instr_d    = imem_data;
                        pc_d       = fetch_pc_q;
                        clk_en_d   = 1'b1;
                        fetch_pc_d = fetch_pc_q + PcIncr;
                    end else begin
                        clk_en_d = 1'b0;
                    end
                end
                StDiscard: begin
                    if (!prev_stall) begin
                        clk_en_d = 1'b0;
                        if (prev_flush) begin
                            instr_d    = NOP_INSTR;
                            skid_clear = 1'b1;
                        end
                    end
                    if (ack_v) begin
                        fetch_pc_d = redirect_q;
                        state_d    = StFetch;
                    end
                end
                StBuffered: begin
                    if (!prev_stall) begin
                        if (prev_flush || !skid_valid) begin
                            clk_en_d   = 1'b0;
                            instr_d    = NOP_INSTR;
                            skid_clear = 1'b1;
                        end else begin
                            instr_d    = skid_instr;
                            pc_d       = skid_pc;
                            clk_en_d   = 1'b1;
                            skid_drain = 1'b1;
                        end
                        state_d = StFetch;
                    end
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end

        // Request stays up in every state except while the skid holds an instruction.
        req_d = (state_d != StBuffered);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFetch;
            fetch_pc_q <= PC_RESET;
            redirect_q <= PC_RESET;
            req_q      <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= PC_RESET;
            clk_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            redirect_q <= redirect_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            clk_en_q   <= clk_en_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = fetch_pc_q;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign clk_en    = clk_en_q;

endmodule

// File: tb/tb_instr_fe.sv
// Bench for instr_fe: variable-latency memory model, output model and delivery scoreboard.
module tb_instr_fe;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        clk_en;
    logic        prev_stall = 1'b0;
    logic        prev_flush = 1'b0;
    logic        change_pc = 1'b0;
    logic [31:0] new_pc = '0;

    instr_fe dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_ack   (imem_ack),
        .instr      (instr),
        .pc         (pc),
        .clk_en     (clk_en),
        .prev_stall (prev_stall),
        .prev_flush (prev_flush),
        .change_pc  (change_pc),
        .new_pc     (new_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    typedef struct {
        logic        st;
        logic        fl;
        logic        ch;
        logic [31:0] np;
        logic        ce;
        logic [31:0] pc;
    } vec_t;

    item_t       sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          lat = 0;
    int          wcnt = 0;
    logic [31:0] held_addr = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_instr = Nop;
    logic        exp_ce = 1'b0;
    logic        exp_req = 1'b0;
    bit          skid = 0;
    bit          discard = 0;
    bit          deliver = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[17:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        wcnt = 0; skid = 0; discard = 0; deliver = 0;
        exp_addr = '0; exp_pc = '0; exp_instr = Nop; exp_ce = 1'b0; exp_req = 1'b0;
    endtask

    task automatic sample_edge();
        item_t it;
        @(negedge clk);
        if (deliver) begin
            deliver = 0;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard: got an empty queue, expected a pending item");
            end else begin
                it = sb.pop_front();
                exp_pc = it.pc;
                exp_instr = it.instr;
                exp_ce = 1'b1;
            end
        end
        chk("clk_en", {31'b0, clk_en}, {31'b0, exp_ce});
        chk("instr", instr, exp_instr);
        chk("pc", pc, exp_pc);
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (imem_req) begin
            if (wcnt != 0) chk("imem_addr_stable", imem_addr, held_addr);
            else if (!discard) chk("imem_addr", imem_addr, exp_addr);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic ch, input logic [31:0] np);
        logic ack;
        prev_stall = st; prev_flush = fl; change_pc = ch; new_pc = np;
        ack = 1'b0;
        if (imem_req) begin
            if (wcnt == 0) held_addr = imem_addr;
            ack = (wcnt >= lat);
            wcnt = ack ? 0 : wcnt + 1;
        end
        imem_ack = ack;
        imem_data = ack ? mdata(imem_addr) : $urandom;
        if (ch) begin
            exp_ce = 1'b0; exp_instr = Nop;
            if (skid) void'(sb.pop_back());
            skid = 0;
            discard = imem_req && !ack;
            exp_addr = np & ~32'h3;
        end else if (discard) begin
            if (!st) begin
                exp_ce = 1'b0;
                if (fl) exp_instr = Nop;
            end
            if (ack) discard = 0;
        end else if (skid) begin
            if (!st) begin
                skid = 0;
                if (fl) begin
                    exp_ce = 1'b0; exp_instr = Nop;
                    void'(sb.pop_back());
                end else begin
                    deliver = 1;
                end
            end
        end else if (st) begin
            if (ack) begin
                sb.push_back('{pc: imem_addr, instr: imem_data});
                skid = 1;
                exp_addr = exp_addr + 32'd4;
            end
        end else if (fl) begin
            exp_ce = 1'b0; exp_instr = Nop;
            if (ack) exp_addr = exp_addr + 32'd4;
        end else if (ack) begin
            sb.push_back('{pc: imem_addr, instr: imem_data});
            deliver = 1;
            exp_addr = exp_addr + 32'd4;
        end else begin
            exp_ce = 1'b0;
        end
        exp_req = !skid;
    endtask

    task automatic cycle(input logic st, input logic fl, input logic ch, input logic [31:0] np);
        sample_edge();
        drive(st, fl, ch, np);
    endtask

    // Runs plain cycles until a request to addr is waiting; returns after a sample, before drive.
    task automatic until_pending(input logic [31:0] addr, output bit found);
        found = 0;
        for (int i = 0; i < 16; i++) begin
            sample_edge();
            if (imem_req && imem_addr == addr && wcnt > 0) begin
                found = 1;
                return;
            end
            drive(1'b0, 1'b0, 1'b0, '0);
        end
        sample_edge();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imem_req"}, {31'b0, imem_req}, 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, 32'h0);
        chk({tag, "_instr"}, instr, Nop);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_clk_en"}, {31'b0, clk_en}, 32'd0);
    endtask

    vec_t        vecs[12];
    bit          found;
    bit          got;
    logic [31:0] first_pc;
    logic [31:0] stall_addr;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h18};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h18};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200};

        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        exp_req = 1'b1;

        // Zero-wait memory: streaming, stall/skid, flush with ack, redirect with ack.
        lat = 0;
        foreach (vecs[i]) begin
            sample_edge();
            chk($sformatf("vec%0d_clk_en", i), {31'b0, clk_en}, {31'b0, vecs[i].ce});
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
            drive(vecs[i].st, vecs[i].fl, vecs[i].ch, vecs[i].np);
        end

        // Two wait states per fetch: clk_en pulses with two bubbles between.
        lat = 2;
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, '0);

        // Four-cycle stall with the ack landing in its second cycle.
        lat = 1;
        found = 0;
        for (int i = 0; i < 8; i++) begin
            sample_edge();
            if (imem_req && wcnt == 0 && !discard) begin
                found = 1;
                break;
            end
            drive(1'b0, 1'b0, 1'b0, '0);
        end
        chk("stall_fresh_request", {31'b0, found}, 32'd1);
        stall_addr = imem_addr;
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        sample_edge();
        chk("stall_release_clk_en", {31'b0, clk_en}, 32'd1);
        chk("stall_release_pc", pc, stall_addr);
        drive(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, '0);

        // Redirect while the request to 0x8 is pending; its response is discarded.
        lat = 3;
        cycle(1'b0, 1'b0, 1'b1, 32'h8);
        until_pending(32'h8, found);
        chk("pending_0x8", {31'b0, found}, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 32'h202);
        got = 0;
        first_pc = '0;
        for (int i = 0; i < 20; i++) begin
            sample_edge();
            if (clk_en) begin
                got = 1;
                first_pc = pc;
                drive(1'b0, 1'b0, 1'b0, '0);
                break;
            end
            drive(1'b0, 1'b0, 1'b0, '0);
        end
        chk("redirect_delivered", {31'b0, got}, 32'd1);
        chk("redirect_first_pc", first_pc, 32'h200);

        // PC wrap from the top of the address space.
        lat = 0;
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, '0);

        // Asynchronous reset while the request to 0x40 is outstanding.
        lat = 3;
        cycle(1'b0, 1'b0, 1'b1, 32'h40);
        until_pending(32'h40, found);
        chk("pending_0x40", {31'b0, found}, 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        model_reset();
        prev_stall = 1'b0; prev_flush = 1'b0; change_pc = 1'b0;
        imem_ack = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_req = 1'b1;
        lat = 0;
        sample_edge();
        chk("restart_addr", imem_addr, 32'h0);
        drive(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, '0);
        sample_edge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
